mandel_pixel_scheduler: RTL and testbench
=========================================

Name: mandel_pixel_scheduler

Overview:
Master-side partner of the single-multiplier Mandelbrot iterator. It scans a rectangular pixel grid in row-major order and generates the 4.23 fixed-point c_r/c_i for each pixel. It issues one job at a time over the iterator's input val/rdy handshake, then collects the escape count over the iterator's output val/rdy handshake. Each result is forwarded as an addressed write to the frame-buffer writer; the block sits between the frame-start control and the iterator.

Parameters:
H_PIX, 640, pixels per row (>=1)
V_PIX, 480, rows per frame (>=1)
ITER_W, 11, width of iteration count; must equal the iterator's iter_count width
ADDR_W, $clog2(H_PIX*V_PIX), pixel address width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  frame request; sampled only in IDLE
x0  in  27  signed 4.23, c_r of pixel (0,0); latched on accepted start
y0  in  27  signed 4.23, c_i of pixel (0,0); latched on accepted start
dx  in  27  signed 4.23, c_r step per column; latched on accepted start
dy  in  27  signed 4.23, c_i step per row; latched on accepted start
busy  out  1  high from the cycle after start is accepted until return to IDLE
done  out  1  one-cycle pulse after the last pixel write completes
it_in_val  out  1  job valid to iterator
it_in_rdy  in  1  iterator ready for job
it_c_r  out  27  signed job real coordinate
it_c_i  out  27  signed job imaginary coordinate
it_out_val  in  1  iterator result valid
it_out_rdy  out  1  scheduler ready for result
it_iter_count  in  ITER_W  result count
pix_we  out  1  pixel write valid
pix_rdy  in  1  writer accepts pixel
pix_addr  out  ADDR_W  row*H_PIX + col
pix_iter  out  ITER_W  captured iteration count

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, it_in_val, it_out_rdy, pix_we=0; col, row, pix_addr, it_c_r, it_c_i, pix_iter=0. Reset mid-frame abandons the frame immediately; the next start restarts at pixel 0.
- States: IDLE, ISSUE, WAIT, WRITE, FIN. All outputs are decoded from registered state or held registers, with no combinational path from any input to any output.
- IDLE: start=1 latches x0/y0/dx/dy, sets it_c_r=x0, it_c_i=y0, col=row=pix_addr=0, and moves to ISSUE. start is ignored in every other state.
- ISSUE: it_in_val=1 with it_c_r/it_c_i stable. When it_in_val&it_in_rdy, go to WAIT. Hold indefinitely while it_in_rdy=0.
- WAIT: it_out_rdy=1. When it_out_val, capture pix_iter=it_iter_count and go to WRITE. An it_out_val that arrives outside WAIT is not accepted (it_out_rdy=0).
- WRITE: pix_we=1 with pix_addr/pix_iter stable until pix_rdy. On pix_we&pix_rdy:
  - Last pixel (col=H_PIX-1 and row=V_PIX-1): go to FIN.
  - End of row (col=H_PIX-1): col=0, row+1, it_c_r=x0_lat, it_c_i+=dy, go to ISSUE.
  - Otherwise: col+1, it_c_r+=dx, go to ISSUE.
  - pix_addr increments by 1 on every completed write, using a running counter with no multiplier.
- FIN: done=1 for exactly one cycle, then IDLE. busy=0 in FIN and IDLE.
- Arithmetic: 27-bit two's-complement add; overflow wraps silently with no saturation.
- Steady-state minimum per pixel: 1 ISSUE cycle + 1 WAIT cycle + 1 WRITE cycle, plus the iterator's own latency.
- H_PIX=1 or V_PIX=1 must work: the row wrap and last-pixel test can be true together, and the last-pixel test takes priority.
- Exactly one job is outstanding at a time; there is never a second it_in_val before the prior result is accepted.

Test Plan:
- H_PIX=4, V_PIX=3, x0=-2.0 (27'h7000000), y0=-1.0, dx=0.5, dy=0.5, iterator model returning count=col+row, all rdy=1 -> 12 writes, pix_addr 0..11 in order, pix_iter[k]=k%4+k/4, it_c_r sequence -2,-1.5,-1,-0.5 repeating, it_c_i steps -1,-0.5,0 per row, then one done pulse and busy falls.
- Backpressure: it_in_rdy low 5 cycles, iterator result delayed 20 cycles, pix_rdy low 3 cycles on pixel 2 -> it_in_val/pix_we and their data held stable throughout; no duplicate or missing addresses.
- start pulsed during WAIT of pixel 5 with different x0 -> ignored; frame completes with the original coordinates.
- Assert reset=0 for one cycle during WRITE of pixel 6 -> all outputs 0 asynchronously; a fresh start produces pixel 0 at it_c_r=x0 and pix_addr=0.
- H_PIX=1, V_PIX=1 -> exactly one ISSUE, one write at address 0, done one cycle after pix_rdy.
- x0=27'h3FFFFFF, dx=1 LSB, H_PIX=2 -> the second pixel's it_c_r=27'h4000000 (wraps negative), no stall.

Source files
------------

// File: rtl/mandel_pixel_scheduler.sv
// Row-major pixel scheduler for a single-multiplier Mandelbrot iterator:
// one job in flight, coordinates stepped incrementally, results written out by address.
module mandel_pixel_scheduler #(
  parameter int H_PIX  = 640,
  parameter int V_PIX  = 480,
  parameter int ITER_W = 11,
  parameter int ADDR_W = (H_PIX * V_PIX > 1) ? $clog2(H_PIX * V_PIX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [26:0]       x0,
  input  logic [26:0]       y0,
  input  logic [26:0]       dx,
  input  logic [26:0]       dy,
  output logic              busy,
  output logic              done,
  output logic              it_in_val,
  input  logic              it_in_rdy,
  output logic [26:0]       it_c_r,
  output logic [26:0]       it_c_i,
  input  logic              it_out_val,
  output logic              it_out_rdy,
  input  logic [ITER_W-1:0] it_iter_count,
  output logic              pix_we,
  input  logic              pix_rdy,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ITER_W-1:0] pix_iter,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on the rising edge where val and rdy are both high;
  // once raised, val and its data stay unchanged until that transfer.

  localparam int COL_W = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int ROW_W = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [26:0]         c_r_q, c_r_d;
  logic [26:0]         c_i_q, c_i_d;
  logic [26:0]         x0_q, x0_d;
  logic [26:0]         dx_q, dx_d;
  logic [26:0]         dy_q, dy_d;
  logic [ITER_W-1:0]   iter_q, iter_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      c_r_q   <= '0;
      c_i_q   <= '0;
      x0_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      c_r_q   <= c_r_d;
      c_i_q   <= c_i_d;
      x0_q    <= x0_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    c_r_d   = c_r_q;
    c_i_d   = c_i_q;
    x0_d    = x0_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = x0;
          dx_d    = dx;
          dy_d    = dy;
          c_r_d   = x0;
          c_i_d   = y0;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (it_in_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (it_out_val) begin
          iter_d  = it_iter_count;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (pix_rdy) begin
          addr_d = addr_q + ADDR_W'(1);
          // Last-pixel test first so 1-wide or 1-tall frames still terminate.
          if (col_q == COL_LAST && row_q == ROW_LAST) begin
            state_d = S_FIN;
          end else if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = row_q + ROW_W'(1);
            c_r_d   = x0_q;
            c_i_d   = c_i_q + dy_q;
            state_d = S_ISSUE;
          end else begin
            col_d   = col_q + COL_W'(1);
            c_r_d   = c_r_q + dx_q;
            state_d = S_ISSUE;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign done       = (state_q == S_FIN);
  assign it_in_val  = (state_q == S_ISSUE);
  assign it_out_rdy = (state_q == S_WAIT);
  assign pix_we     = (state_q == S_WRITE);
  assign it_c_r     = c_r_q;
  assign it_c_i     = c_i_q;
  assign pix_addr   = addr_q;
  assign pix_iter   = iter_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Bench for mandel_pixel_scheduler: a 4x3 frame instance plus a 1x1 instance,
// iterator and frame-buffer writer played by tasks, pixel writes scored against a queue.
module tb_mandel_pixel_scheduler;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;
  localparam int IW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [26:0]   x0 = '0, y0 = '0, dx = '0, dy = '0;
  logic          busy, done, it_in_val, it_out_rdy, pix_we;
  logic          it_in_rdy = 1'b0, it_out_val = 1'b0, pix_rdy = 1'b0;
  logic [26:0]   it_c_r, it_c_i;
  logic [IW-1:0] it_iter_count = '0;
  logic [AW-1:0] pix_addr;
  logic [IW-1:0] pix_iter;
  logic [2:0]    dbg_state;

  logic          s_start = 1'b0;
  logic [26:0]   s_x0 = '0, s_y0 = '0;
  logic          s_busy, s_done, s_in_val, s_out_rdy, s_pix_we;
  logic          s_in_rdy = 1'b0, s_out_val = 1'b0, s_pix_rdy = 1'b0;
  logic [26:0]   s_c_r, s_c_i;
  logic [IW-1:0] s_iter_count = '0;
  logic [0:0]    s_pix_addr;
  logic [IW-1:0] s_pix_iter;
  logic [2:0]    s_dbg_state;

  logic [AW+IW-1:0] exp_q[$];
  logic [26:0]      m_x0, m_y0, m_dx, m_dy;
  int               vectors = 0;
  int               miscompares = 0;

  always #5 clk = ~clk;

  mandel_pixel_scheduler #(.H_PIX(H), .V_PIX(V), .ITER_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .dx(dx), .dy(dy),
    .busy(busy), .done(done), .it_in_val(it_in_val), .it_in_rdy(it_in_rdy),
    .it_c_r(it_c_r), .it_c_i(it_c_i), .it_out_val(it_out_val), .it_out_rdy(it_out_rdy),
    .it_iter_count(it_iter_count), .pix_we(pix_we), .pix_rdy(pix_rdy),
    .pix_addr(pix_addr), .pix_iter(pix_iter), .dbg_state(dbg_state)
  );

  mandel_pixel_scheduler #(.H_PIX(1), .V_PIX(1), .ITER_W(IW)) dut_1x1 (
    .clk(clk), .reset(reset), .start(s_start), .x0(s_x0), .y0(s_y0), .dx(27'h0400000), .dy(27'h0400000),
    .busy(s_busy), .done(s_done), .it_in_val(s_in_val), .it_in_rdy(s_in_rdy),
    .it_c_r(s_c_r), .it_c_i(s_c_i), .it_out_val(s_out_val), .it_out_rdy(s_out_rdy),
    .it_iter_count(s_iter_count), .pix_we(s_pix_we), .pix_rdy(s_pix_rdy),
    .pix_addr(s_pix_addr), .pix_iter(s_pix_iter), .dbg_state(s_dbg_state)
  );

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, it_in_val, it_out_rdy, pix_we} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, it_in_val, it_out_rdy, pix_we});
    end
    vectors++;
    if ({it_c_r, it_c_i, pix_addr, pix_iter} !== '0) begin
      miscompares++; $display("FAIL reset_data: got c_r=%h c_i=%h addr=%0d iter=%0d want all 0", it_c_r, it_c_i, pix_addr, pix_iter);
    end
    vectors++;
    if ({s_busy, s_done, s_in_val, s_out_rdy, s_pix_we} !== 5'b0) begin
      miscompares++; $display("FAIL reset_1x1: got %b want 00000", {s_busy, s_done, s_in_val, s_out_rdy, s_pix_we});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One pixel through the full issue/result/write exchange; returns early on abort.
  task automatic do_pixel(input int k, input int in_stall, input int out_delay, input int pix_stall,
                          input bit glitch, input bit abort, input bit chk_thru);
    int col, row, n;
    logic [26:0] ecr, eci;
    logic [IW-1:0] eiter;
    logic [AW-1:0] eaddr;
    logic [AW+IW-1:0] got, exp;
    col = k % H; row = k / H;
    ecr = m_x0 + m_dx * 27'(col);
    eci = m_y0 + m_dy * 27'(row);
    eiter = IW'(col + row);
    eaddr = AW'(row * H + col);
    n = 0;
    while (it_in_val !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (it_in_val !== 1'b1) begin
      miscompares++; $display("FAIL issue_timeout px%0d: it_in_val=%b want 1", k, it_in_val);
    end
    if (chk_thru) begin
      vectors++;
      if (n != 0) begin miscompares++; $display("FAIL issue_gap px%0d: waited %0d cycles want 0", k, n); end
    end
    vectors++;
    if ({it_c_r, it_c_i} !== {ecr, eci}) begin
      miscompares++; $display("FAIL job_coord px%0d: got c_r=%h c_i=%h want c_r=%h c_i=%h", k, it_c_r, it_c_i, ecr, eci);
    end
    for (int i = 0; i < in_stall; i++) begin
      it_in_rdy = 1'b0; it_out_val = 1'b1;
      @(negedge clk);
      vectors++;
      if ({it_in_val, it_out_rdy, it_c_r, it_c_i} !== {2'b10, ecr, eci}) begin
        miscompares++; $display("FAIL issue_hold px%0d: got val=%b out_rdy=%b c_r=%h c_i=%h want 1 0 %h %h",
                                k, it_in_val, it_out_rdy, it_c_r, it_c_i, ecr, eci);
      end
    end
    it_out_val = 1'b0; it_in_rdy = 1'b1;
    exp_q.push_back({eaddr, eiter});
    @(negedge clk);
    it_in_rdy = 1'b0;
    vectors++;
    if ({it_in_val, it_out_rdy, busy} !== 3'b011) begin
      miscompares++; $display("FAIL wait_state px%0d: got in_val/out_rdy/busy=%b want 011", k, {it_in_val, it_out_rdy, busy});
    end
    for (int i = 0; i < out_delay; i++) begin
      if (glitch && i == 0) begin start = 1'b1; x0 = 27'h1234567; dx = 27'h0000100; end
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if ({it_out_rdy, pix_we, it_in_val} !== 3'b100) begin
        miscompares++; $display("FAIL wait_hold px%0d: got out_rdy/pix_we/in_val=%b want 100", k, {it_out_rdy, pix_we, it_in_val});
      end
    end
    it_iter_count = eiter; it_out_val = 1'b1;
    @(negedge clk);
    it_out_val = 1'b0; it_iter_count = IW'($urandom);
    vectors++;
    if (pix_we !== 1'b1) begin miscompares++; $display("FAIL write_valid px%0d: pix_we=%b want 1", k, pix_we); end
    if (abort) begin
      reset = 1'b0;
      #1;
      vectors++;
      if ({busy, done, it_in_val, it_out_rdy, pix_we, it_c_r, it_c_i, pix_addr, pix_iter} !== '0) begin
        miscompares++; $display("FAIL async_reset px%0d: got ctrl=%b c_r=%h c_i=%h addr=%0d iter=%0d want all 0",
                                k, {busy, done, it_in_val, it_out_rdy, pix_we}, it_c_r, it_c_i, pix_addr, pix_iter);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      return;
    end
    for (int i = 0; i < pix_stall; i++) begin
      pix_rdy = 1'b0;
      @(negedge clk);
      vectors++;
      if ({pix_we, pix_addr, pix_iter} !== {1'b1, eaddr, eiter}) begin
        miscompares++; $display("FAIL write_hold px%0d: got we=%b addr=%0d iter=%0d want 1 %0d %0d", k, pix_we, pix_addr, pix_iter, eaddr, eiter);
      end
    end
    pix_rdy = 1'b1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++; $display("FAIL score_empty px%0d: write at addr=%0d with nothing expected", k, pix_addr);
    end else begin
      got = {pix_addr, pix_iter};
      exp = exp_q.pop_front();
      if (got !== exp) begin
        miscompares++; $display("FAIL pixel_write px%0d: got addr=%0d iter=%0d want addr=%0d iter=%0d",
                                k, got[AW+IW-1:IW], got[IW-1:0], exp[AW+IW-1:IW], exp[IW-1:0]);
      end
    end
    @(negedge clk);
    pix_rdy = 1'b0;
  endtask

  // mode 0: no stalls (checks 3-cycle pixel rate), 1: directed backpressure + start glitch, 2: random stalls
  task automatic run_frame(input logic [26:0] fx0, input logic [26:0] fy0, input logic [26:0] fdx,
                           input logic [26:0] fdy, input int mode, input int abort_at);
    int ins, outd, pxs;
    m_x0 = fx0; m_y0 = fy0; m_dx = fdx; m_dy = fdy;
    x0 = fx0; y0 = fy0; dx = fdx; dy = fdy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_rise: busy=%b want 1", busy); end
    for (int k = 0; k < H * V; k++) begin
      ins = 0; outd = 0; pxs = 0;
      if (mode == 1) begin
        ins  = (k == 0) ? 5 : 0;
        outd = (k == 1) ? 20 : ((k == 5) ? 2 : 0);
        pxs  = (k == 2) ? 3 : 0;
      end else if (mode == 2) begin
        ins = $urandom_range(0, 3); outd = $urandom_range(0, 4); pxs = $urandom_range(0, 2);
      end
      do_pixel(k, ins, outd, pxs, (mode == 1 && k == 5), (k == abort_at), (mode == 0));
      if (k == abort_at) return;
    end
    vectors++;
    if ({done, busy} !== 2'b10) begin miscompares++; $display("FAIL done_pulse: done/busy=%b want 10", {done, busy}); end
    @(negedge clk);
    vectors++;
    if ({done, busy, it_in_val} !== 3'b000) begin
      miscompares++; $display("FAIL frame_end: done/busy/in_val=%b want 000", {done, busy, it_in_val});
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL score_left: %0d writes missing", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_basic_frame();
    run_frame(27'h7000000, 27'h7800000, 27'h0400000, 27'h0400000, 0, -1);
  endtask

  task automatic test_backpressure();
    run_frame(27'h7000000, 27'h7800000, 27'h0400000, 27'h0400000, 1, -1);
  endtask

  task automatic test_abort_restart();
    run_frame(27'h7400000, 27'h7C00000, 27'h0200000, 27'h0100000, 2, 6);
    repeat (2) @(negedge clk);
    run_frame(27'h7400000, 27'h7C00000, 27'h0200000, 27'h0100000, 0, -1);
  endtask

  task automatic test_wrap();
    run_frame(27'h3FFFFFF, 27'h0000000, 27'h0000001, 27'h0000001, 0, -1);
  endtask

  task automatic test_random_frame();
    run_frame(27'($urandom), 27'($urandom), 27'($urandom), 27'($urandom), 2, -1);
  endtask

  task automatic test_single_pixel();
    int n;
    logic [IW-1:0] eiter;
    logic [AW+IW-1:0] exp;
    eiter = IW'($urandom_range(1, 2047));
    s_x0 = 27'h5A5A5A5; s_y0 = 27'h0123456;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_in_val !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if ({s_in_val, s_c_r, s_c_i} !== {1'b1, 27'h5A5A5A5, 27'h0123456}) begin
      miscompares++; $display("FAIL one_issue: got val=%b c_r=%h c_i=%h want 1 5a5a5a5 0123456", s_in_val, s_c_r, s_c_i);
    end
    s_in_rdy = 1'b1;
    exp_q.push_back({AW'(0), eiter});
    @(negedge clk);
    s_in_rdy = 1'b0;
    s_out_val = 1'b1; s_iter_count = eiter;
    @(negedge clk);
    s_out_val = 1'b0;
    s_pix_rdy = 1'b1;
    vectors++;
    exp = exp_q.pop_front();
    if ({s_pix_we, AW'(s_pix_addr), s_pix_iter} !== {1'b1, exp}) begin
      miscompares++; $display("FAIL one_write: got we=%b addr=%0d iter=%0d want 1 0 %0d", s_pix_we, s_pix_addr, s_pix_iter, eiter);
    end
    @(negedge clk);
    s_pix_rdy = 1'b0;
    vectors++;
    if ({s_done, s_busy, s_in_val} !== 3'b100) begin
      miscompares++; $display("FAIL one_done: done/busy/in_val=%b want 100", {s_done, s_busy, s_in_val});
    end
    @(negedge clk);
    vectors++;
    if ({s_done, s_in_val, s_pix_we} !== 3'b000) begin
      miscompares++; $display("FAIL one_idle: done/in_val/pix_we=%b want 000", {s_done, s_in_val, s_pix_we});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_abort_restart();
    test_wrap();
    test_random_frame();
    test_single_pixel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
